// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
//   Write-back commit tracer. Every register-file write committed at the end
//   of the WB stage is recorded as {cycle, register address, data} into a
//   circular FIFO that a consumer drains through a valid/ready handshake.
//   Commits that arrive while the FIFO is full (and nothing is popped in the
//   same cycle) are dropped and accounted for in sticky overflow/drop counters.
//
// Optional feature macro: WB_TRACE_R0_FILTER_EN
//   Defined   : writes to r0 are ignored (never stored, never counted as drops).
//   Undefined : writes to r0 are recorded like any other register.
//
// Parameters
//   DEPTH  : number of FIFO entries (power of two, >= 2)
//   DATA_W : width of the write-back data
//   CYC_W  : width of the cycle timestamp
//
// Ports
//   clk_i         in  : clock, all state updates on the rising edge
//   rst_i         in  : synchronous active-low reset
//   wb_en_i       in  : register-file write enable from WB
//   wb_addr_i     in  : destination register number
//   wb_data_i     in  : data being written
//   trace_valid_o out : head entry available
//   trace_ready_i in  : consumer accepts the head entry
//   trace_addr_o  out : head entry register number
//   trace_data_o  out : head entry data
//   trace_cycle_o out : head entry timestamp
//   count_o       out : number of entries held
//   overflow_o    out : sticky, set when any commit was dropped
//   drop_cnt_o    out : dropped commits, saturating at 255
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int CYC_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_en_i,
  input  logic [4:0]               wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [4:0]               trace_addr_o,
  output logic [DATA_W-1:0]        trace_data_o,
  output logic [CYC_W-1:0]         trace_cycle_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CYC_W + 5 + DATA_W;

  // Entry storage; no reset needed since pointers define what is live.
  logic [ENT_W-1:0]  r_mem [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_valid;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;
  logic [4:0]        r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CYC_W-1:0]  r_cycle;

  logic              w_commit;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_bypass;
  logic [CNT_W-1:0]  w_count_next;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [ENT_W-1:0]  w_entry_in;
  logic [ENT_W-1:0]  w_head_next;

`ifdef WB_TRACE_R0_FILTER_EN
  assign w_commit = wb_en_i && (wb_addr_i != 5'd0);
`else
  assign w_commit = wb_en_i;
`endif

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = r_valid && trace_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push     = w_commit && (!w_full || w_pop);
  assign w_drop     = w_commit && w_full && !w_pop;
  assign w_entry_in = {r_cyc, wb_addr_i, wb_data_i};

  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // The incoming commit becomes the head when nothing else remains after
  // this cycle's pop; the array slot is not written until this same edge,
  // so forward the entry directly into the output register.
  assign w_bypass    = w_push && (w_count_next == CNT_W'(1));
  assign w_head_next = w_bypass ? w_entry_in : r_mem[w_rd_ptr_next];

  always_ff @(posedge clk_i) begin
    if (rst_i && w_push) begin
      r_mem[r_wr_ptr] <= w_entry_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cyc      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cycle    <= '0;
    end else begin
      r_cyc    <= r_cyc + CYC_W'(1);
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
      // Head fields only change when there is a head to present; with no
      // pop the read pointer and its slot are stable, so outputs hold.
      if (w_count_next != '0) begin
        {r_cycle, r_addr, r_data} <= w_head_next;
      end
    end
  end

  assign trace_valid_o = r_valid;
  assign trace_addr_o  = r_addr;
  assign trace_data_o  = r_data;
  assign trace_cycle_o = r_cycle;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo
//   Directed bench for wb_trace_fifo. A queue-based reference model tracks
//   what the commit log must contain; a compare process checks every cycle,
//   and directed sequences pin the model with hand-computed literals.
module tb_wb_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int CYC_W  = 16;

  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              wb_en_i;
  logic [4:0]        wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              trace_valid_o;
  logic              trace_ready_i;
  logic [4:0]        trace_addr_o;
  logic [DATA_W-1:0] trace_data_o;
  logic [CYC_W-1:0]  trace_cycle_o;
  logic [4:0]        count_o;
  logic              overflow_o;
  logic [7:0]        drop_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .trace_addr_o  (trace_addr_o),
    .trace_data_o  (trace_data_o),
    .trace_cycle_o (trace_cycle_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t            m_q[$];
  logic [CYC_W-1:0] m_cyc;
  bit               m_ovf;
  int               m_drops;
  bit               m_live = 0;

  task automatic model_step();
    bit   commit;
    bit   pop;
    bit   full;
    ent_t e;
    if (!rst_i) begin
      m_q.delete();
      m_cyc   = '0;
      m_ovf   = 0;
      m_drops = 0;
      m_live  = 1;
    end else if (m_live) begin
`ifdef WB_TRACE_R0_FILTER_EN
      commit = wb_en_i && (wb_addr_i != 5'd0);
`else
      commit = wb_en_i;
`endif
      pop  = (m_q.size() > 0) && trace_ready_i;
      full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (commit) begin
        if (full && !pop) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          e.cyc  = m_cyc;
          e.addr = wb_addr_i;
          e.data = wb_data_i;
          m_q.push_back(e);
        end
      end
      m_cyc = m_cyc + 1'b1;
    end
  endtask

  always @(posedge clk) model_step();

  // Compare process: outputs settle after posedge, checked on negedge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_valid", 64'(trace_valid_o), 64'(m_q.size() > 0));
      chk("model_count", 64'(count_o), 64'(m_q.size()));
      chk("model_overflow", 64'(overflow_o), 64'(m_ovf));
      chk("model_drops", 64'(drop_cnt_o), 64'(m_drops));
      if (m_q.size() > 0) begin
        chk("model_addr", 64'(trace_addr_o), 64'(m_q[0].addr));
        chk("model_data", 64'(trace_data_o), 64'(m_q[0].data));
        chk("model_cycle", 64'(trace_cycle_o), 64'(m_q[0].cyc));
      end
    end
  end

  task automatic commit_one(input logic [4:0] a, input logic [DATA_W-1:0] d);
    wb_en_i   = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
    @(negedge clk);
    wb_en_i   = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; trace_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    // Reset state (this cycle has counter value 0)
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_addr", 64'(trace_addr_o), 64'd0);
    chk("rst_data", 64'(trace_data_o), 64'd0);
    chk("rst_cycle", 64'(trace_cycle_o), 64'd0);
    $display("txn reset: done");

    // Single commit at counter value 3
    repeat (3) @(negedge clk);
    commit_one(5'd5, 32'h0000_002A);
    chk("single_valid", 64'(trace_valid_o), 64'd1);
    chk("single_addr", 64'(trace_addr_o), 64'd5);
    chk("single_data", 64'(trace_data_o), 64'd42);
    chk("single_cycle", 64'(trace_cycle_o), 64'd3);
    chk("single_count", 64'(count_o), 64'd1);
    trace_ready_i = 1'b1;
    @(negedge clk);
    trace_ready_i = 1'b0;
    chk("single_pop_valid", 64'(trace_valid_o), 64'd0);
    chk("single_pop_count", 64'(count_o), 64'd0);
    $display("txn single commit r5=42: done");

    // Backpressure and order
    for (int i = 1; i <= 4; i++) commit_one(5'(i), 32'(i * 10));
    for (int k = 0; k < 3; k++) begin
      chk("bp_head_addr", 64'(trace_addr_o), 64'd1);
      chk("bp_head_data", 64'(trace_data_o), 64'd10);
      chk("bp_count", 64'(count_o), 64'd4);
      @(negedge clk);
    end
    trace_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_order_data", 64'(trace_data_o), 64'(i * 10));
      chk("bp_order_valid", 64'(trace_valid_o), 64'd1);
      @(negedge clk);
    end
    trace_ready_i = 1'b0;
    chk("bp_drained", 64'(trace_valid_o), 64'd0);
    $display("txn backpressure r1..r4: done");

    // Overflow: 18 commits into 16 slots
    for (int i = 0; i < 18; i++) commit_one(5'((i % 31) + 1), 32'(100 + i));
    chk("ovf_count", 64'(count_o), 64'd16);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_drops", 64'(drop_cnt_o), 64'd2);
    $display("txn overflow 18 commits: done");

    // Full with simultaneous push and pop
    trace_ready_i = 1'b1;
    commit_one(5'd9, 32'd99);
    trace_ready_i = 1'b0;
    chk("fullpp_count", 64'(count_o), 64'd16);
    chk("fullpp_drops", 64'(drop_cnt_o), 64'd2);
    trace_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_drain_data", 64'(trace_data_o), (i < 15) ? 64'(101 + i) : 64'd99);
      @(negedge clk);
    end
    trace_ready_i = 1'b0;
    chk("fullpp_empty", 64'(count_o), 64'd0);
    $display("txn full push+pop data 99: done");

    // Sustained throughput: one in, one out per cycle
    trace_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      commit_one(5'(i + 1), 32'(200 + i));
      wb_en_i = 1'b0;
      chk("tput_data", 64'(trace_data_o), 64'(200 + i));
      chk("tput_count", 64'(count_o), 64'd1);
      if (i < 7) begin
        wb_en_i = 1'b1;
      end
    end
    wb_en_i = 1'b0;
    @(negedge clk);
    trace_ready_i = 1'b0;
    chk("tput_empty", 64'(count_o), 64'd0);
    $display("txn throughput 8 commits: done");

    // r0 filter
    commit_one(5'd0, 32'd7);
`ifdef WB_TRACE_R0_FILTER_EN
    chk("r0_count", 64'(count_o), 64'd0);
    chk("r0_valid", 64'(trace_valid_o), 64'd0);
`else
    chk("r0_count", 64'(count_o), 64'd1);
    chk("r0_addr", 64'(trace_addr_o), 64'd0);
    chk("r0_data", 64'(trace_data_o), 64'd7);
    trace_ready_i = 1'b1;
    @(negedge clk);
    trace_ready_i = 1'b0;
`endif
    $display("txn r0 commit data 7: done");

    // Reset mid-operation
    for (int i = 0; i < 5; i++) commit_one(5'(i + 10), 32'(300 + i));
    chk("mid_count", 64'(count_o), 64'd5);
    chk("mid_ovf", 64'(overflow_o), 64'd1);
    rst_i = 1'b0; wb_en_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 32'd66;
    @(negedge clk);
    rst_i = 1'b1; wb_en_i = 1'b0;
    chk("midrst_valid", 64'(trace_valid_o), 64'd0);
    chk("midrst_count", 64'(count_o), 64'd0);
    chk("midrst_ovf", 64'(overflow_o), 64'd0);
    chk("midrst_drops", 64'(drop_cnt_o), 64'd0);
    chk("midrst_addr", 64'(trace_addr_o), 64'd0);
    chk("midrst_data", 64'(trace_data_o), 64'd0);
    chk("midrst_cycle", 64'(trace_cycle_o), 64'd0);
    commit_one(5'd3, 32'd55);
    chk("restart_cycle", 64'(trace_cycle_o), 64'd0);
    chk("restart_addr", 64'(trace_addr_o), 64'd3);
    chk("restart_count", 64'(count_o), 64'd1);
    trace_ready_i = 1'b1;
    @(negedge clk);
    trace_ready_i = 1'b0;
    chk("restart_drained", 64'(count_o), 64'd0);
    $display("txn reset mid-operation: done");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
